bus_copy_master: RTL and testbench
==================================

# bus_copy_master

Bus master that sits directly upstream of the shared BUS interconnect and drives its master port. It copies a block of 64-bit words from a source address range to a destination address range through the bus. Each word takes one read transaction followed by one write transaction. A local start/done interface lets a controller launch copies without driving bus signals itself.

## Interface
Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 64, bus data width
- LEN_W, 8, word-count width; max copy is 2^LEN_W-1 words

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle launch pulse; sampled only in IDLE
- src_addr  input  ADDR_W  first source word address; latched on accepted start
- dst_addr  input  ADDR_W  first destination word address; latched on accepted start
- len  input  LEN_W  number of words; latched on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the copy completes
- checksum  output  DATA_W  XOR of all copied words (see Configuration)
- m_req  output  1  bus request
- m_wr  output  1  1 = write, 0 = read
- m_addr  output  ADDR_W  bus address
- m_dout  output  DATA_W  write data to bus
- m_grant  input  1  bus grant
- m_din  input  DATA_W  read data from bus; valid one cycle after a read address is presented

## Operation
- All outputs are registered.
- Reset values: busy=0, done=0, checksum=0, m_req=0, m_wr=0, m_addr=0, m_dout=0. The FSM resets to IDLE.
- Internal registers: src_ptr, dst_ptr, remaining, buf.

FSM states and transitions:
- IDLE:
  - start with len≠0 → latch src_ptr, dst_ptr, remaining; clear checksum; go to REQ.
  - start with len=0 → DONE; the bus is never requested.
- REQ: m_req=1, m_wr=0. Wait for m_grant=1, then go to RD.
- RD: m_addr=src_ptr, m_wr=0. If m_grant=1, go to RDW; otherwise hold in RD.
- RDW: capture buf←m_din unconditionally. Increment src_ptr. Go to WR.
- WR: m_addr=dst_ptr, m_wr=1, m_dout=buf. If m_grant=1:
  - increment dst_ptr and decrement remaining;
  - remaining reaches 0 → DONE, else → RD.
  - Otherwise hold in WR.
- DONE: m_req=0, m_wr=0, done=1 for exactly one cycle, busy=0 afterwards. Go to IDLE.

Rules:
- m_req stays high continuously from REQ through the final WR; the bus is never released between words.
- Pointers increment modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000 with no error.
- start while busy is ignored, including start in the DONE cycle.
- Loss of grant mid-copy freezes all state and bus outputs until grant returns. Data already captured in buf is preserved.
- Asynchronous reset mid-copy aborts immediately and returns all outputs to reset values. No done pulse is generated.
- Overlapping source and destination ranges are not detected. The copy runs in ascending-address order.

## Timing
- Accepted start at edge N: busy=1 and m_req=1 after edge N+1.
- With m_grant held high, per-word cost is 3 cycles (RD, RDW, WR).
- Copy of L words with immediate grant: done pulse 2+3L cycles after the start edge.
- len=0: done pulses after edge N+1, and busy never asserts.
- Read data is sampled at the end of RDW, i.e. one cycle after the read address is presented. This matches the interconnect's registered slave-data return.

## Configuration
- COPY_CHECKSUM_EN defined: checksum←checksum XOR buf on every RDW. The final value is valid at done and held until the next accepted start.
- COPY_CHECKSUM_EN undefined: checksum is tied to 0 and no XOR logic is synthesized.
- All other behaviour and timing are identical with or without the macro.

## Structure
- Shared package bus_pkg:
  - ADDR_W and DATA_W constants.
  - Slave address-map constants, identical to those used by the BUS decoder: S0 at 16'h0000–16'h001F, S1 at 16'h7000–16'h701F.
  - copy_state_t enum: IDLE, REQ, RD, RDW, WR, DONE.
- Sub-module copy_checksum: XOR accumulator with clear and enable, instantiated only under COPY_CHECKSUM_EN.

## Test plan
- Single word: S0 model returns 64'd1234 at 16'h0005. Copy src=16'h0005, dst=16'h7001, len=1 with grant held high → read of 16'h0005 with m_wr=0, then write of 16'h7001 with m_wr=1 and m_dout=1234, done 5 cycles after start, checksum=1234.
- Four words: S0 holds 1, 2, 3, 4 at 16'h0000–16'h0003. Copy to dst=16'h7010 → S1 receives the words in order at 16'h7010–16'h7013, done 14 cycles after start, checksum=4 (1^2^3^4).
- Wrap-around: src=16'hFFFF, len=2 → read addresses 16'hFFFF then 16'h0000.
- Grant stall and special starts:
  - Drop m_grant for 3 cycles during WR → m_addr/m_dout held, no extra write, done delayed by exactly 3 cycles.
  - len=0 → done pulse after 1 cycle, m_req never asserts.
  - Start pulsed while busy → ignored; the copy result is unchanged.
- Reset mid-copy: assert reset during the second word's RDW → m_req=0, busy=0, done=0 immediately. A new start after release copies correctly.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared BUS definitions: bus widths, slave address map and copy FSM states.
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    // Slave address map, identical to the one the BUS decoder uses
    localparam logic [15:0] S0_BASE = 16'h0000;
    localparam logic [15:0] S0_LAST = 16'h001F;
    localparam logic [15:0] S1_BASE = 16'h7000;
    localparam logic [15:0] S1_LAST = 16'h701F;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        RDW,
        WR,
        DONE
    } copy_state_t;

endpackage

// File: rtl/copy_checksum.sv
// XOR accumulator over copied words; clear wins over enable.
module copy_checksum #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    // Running XOR, restarted at each accepted copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    sum <= '0;
        else if (clr) sum <= '0;
        else if (en)  sum <= sum ^ din;
    end

endmodule

// File: rtl/bus_copy_master.sv
// Block-copy bus master: one read then one write per 64-bit word, holding
// the bus from the first read through the last write.
// Optional feature macro: COPY_CHECKSUM_EN (XOR checksum of copied words;
// checksum reads 0 when undefined).
//
// Bus outputs are loaded on the edge that enters RD/WR so the address is on
// the bus for the whole RD cycle; read data then arrives in RDW. busy/done
// are loaded from the current state, so done appears the cycle after DONE.
module bus_copy_master #(
    parameter int ADDR_W = bus_pkg::ADDR_W,
    parameter int DATA_W = bus_pkg::DATA_W,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din
);

    import bus_pkg::*;

    copy_state_t       state, state_nx;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] buf_q;

    logic              busy_nx, done_nx, req_nx, wr_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              latch, rd_cap, wr_ack;

    // Write data always comes straight from the captured read word
    assign m_dout = buf_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state, next registered outputs and datapath strobes
    always_comb begin
        state_nx = state;
        busy_nx  = busy;
        done_nx  = 1'b0;
        req_nx   = m_req;
        wr_nx    = m_wr;
        addr_nx  = m_addr;
        latch    = 1'b0;
        rd_cap   = 1'b0;
        wr_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = REQ;
                        latch    = 1'b1;
                    end
                end
            end
            REQ: begin
                // Present the first source address with the request so a
                // grant arriving late never sees a stale address
                req_nx  = 1'b1;
                busy_nx = 1'b1;
                wr_nx   = 1'b0;
                addr_nx = src_ptr;
                if (m_grant) state_nx = RD;
            end
            RD: begin
                if (m_grant) state_nx = RDW;
            end
            RDW: begin
                rd_cap   = 1'b1;
                state_nx = WR;
                wr_nx    = 1'b1;
                addr_nx  = dst_ptr;
            end
            WR: begin
                if (m_grant) begin
                    wr_ack = 1'b1;
                    wr_nx  = 1'b0;
                    if (remaining == LEN_W'(1)) begin
                        state_nx = DONE;
                        req_nx   = 1'b0;
                    end else begin
                        state_nx = RD;
                        addr_nx  = src_ptr;
                    end
                end
            end
            DONE: begin
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                req_nx   = 1'b0;
                wr_nx    = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered control and bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            m_req  <= 1'b0;
            m_wr   <= 1'b0;
            m_addr <= '0;
        end else begin
            busy   <= busy_nx;
            done   <= done_nx;
            m_req  <= req_nx;
            m_wr   <= wr_nx;
            m_addr <= addr_nx;
        end
    end

    // Pointers, word count and read buffer; pointers wrap modulo 2^ADDR_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            buf_q     <= '0;
        end else begin
            if (latch) begin
                src_ptr   <= src_addr;
                dst_ptr   <= dst_addr;
                remaining <= len;
            end
            if (rd_cap) begin
                buf_q   <= m_din;
                src_ptr <= src_ptr + 1'b1;
            end
            if (wr_ack) begin
                dst_ptr   <= dst_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

`ifdef COPY_CHECKSUM_EN
    copy_checksum #(.DATA_W(DATA_W)) u_checksum (
        .clk   (clk),
        .reset (reset),
        .clr   (latch),
        .en    (rd_cap),
        .din   (m_din),
        .sum   (checksum)
    );
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: a memory-backed slave with registered read
// return, a sequential copy model, and a monitor comparing every granted
// write against the model as it happens.
module tb_bus_copy_master;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int LW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done;
    logic [DW-1:0] checksum;
    logic          m_req, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic          m_grant = 1'b1;
    logic [DW-1:0] m_din;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    txn_t          exp_w[$];
    logic [AW-1:0] exp_r[$];
    logic [AW-1:0] rlog[$];
    logic [DW-1:0] model_cs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_copy_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_grant  (m_grant),
        .m_din    (m_din)
    );

    function automatic logic [DW-1:0] init_val(int i);
        if (i < 4)  return 64'(i + 1);
        if (i == 5) return 64'd1234;
        return {32'(i) * 32'h9E37_79B1, 32'(i) ^ 32'hA5A5_0000};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Slave plus compare process: sample the bus mid-cycle, check it, then
    // perform the transaction on the following rising edge
    initial begin : slave_monitor
        logic          s_rst, s_req, s_gnt, s_wr, s_busy, s_done, last_rd;
        logic [AW-1:0] s_addr, last_raddr;
        logic [DW-1:0] s_dout;
        txn_t          t;
        last_rd = 1'b0;
        last_raddr = '0;
        for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
        m_din <= '0;
        forever begin
            @(negedge clk);
            #2;
            s_rst = reset; s_req = m_req; s_gnt = m_grant; s_wr = m_wr;
            s_addr = m_addr; s_dout = m_dout; s_busy = busy; s_done = done;
            if (!s_rst) begin
                if (s_done) check("done_excl", {62'd0, s_busy, s_req}, 64'd0);
                if (s_wr)   check("wr_has_req", 64'(s_req), 64'd1);
            end
            @(posedge clk);
            if (!s_rst && s_req && s_gnt) begin
                if (s_wr) begin
                    mem[s_addr] <= s_dout;
                    last_rd = 1'b0;
                    if (exp_w.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: addr %0h data %0h, none expected", s_addr, s_dout);
                    end else begin
                        t = exp_w.pop_front();
                        check("wr_addr", 64'(s_addr), 64'(t.addr));
                        check("wr_data", s_dout, t.data);
                    end
                end else begin
                    m_din <= mem[s_addr];
                    if (rlog.size() == 0 || !last_rd || last_raddr != s_addr) rlog.push_back(s_addr);
                    last_rd = 1'b1;
                    last_raddr = s_addr;
                end
            end
        end
    end

    // mode 0: grant held high, 1: random grant, 2: grant dropped 3 cycles in first WR
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l,
                            input int mode, input int exp_cyc, input bit poke, input string tag);
        logic [DW-1:0] v, exp_ck, hold_d;
        logic [AW-1:0] a, b, hold_a;
        int            cyc, stall_left, limit;
        bit            stalled, saw_req, saw_busy;
        model_cs = '0;
        exp_r.delete();
        rlog.delete();
        for (int i = 0; i < int'(l); i++) begin
            a = s + 16'(i);
            b = d + 16'(i);
            v = ref_mem[a];
            exp_w.push_back({b, v});
            exp_r.push_back(a);
            ref_mem[b] = v;
            model_cs ^= v;
        end
`ifdef COPY_CHECKSUM_EN
        exp_ck = model_cs;
`else
        exp_ck = '0;
`endif
        limit = 12 * int'(l) + 40;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1; m_grant = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 8'($urandom);
        cyc = 0; stall_left = 0; stalled = 0; saw_req = 0; saw_busy = 0;
        hold_a = '0; hold_d = '0;
        while (!done && cyc < limit) begin
            if (mode == 1) m_grant = ($urandom_range(0, 3) != 0);
            start = poke && (cyc == 2 || cyc == exp_cyc - 1);
            @(posedge clk);
            cyc++;
            @(negedge clk);
            saw_req |= m_req;
            saw_busy |= busy;
            if (mode == 2) begin
                if (stall_left > 0) begin
                    check({tag, "/stall_addr"}, 64'(m_addr), 64'(hold_a));
                    check({tag, "/stall_dout"}, m_dout, hold_d);
                    stall_left--;
                    if (stall_left == 0) m_grant = 1'b1;
                end else if (!stalled && m_req && m_wr) begin
                    stalled = 1; hold_a = m_addr; hold_d = m_dout;
                    stall_left = 3; m_grant = 1'b0;
                end
            end
        end
        start = 1'b0;
        m_grant = 1'b1;
        check({tag, "/done_seen"}, 64'(done), 64'd1);
        if (exp_cyc >= 0) check({tag, "/done_cycle"}, 64'(cyc), 64'(exp_cyc));
        if (mode == 2) check({tag, "/stall_hit"}, 64'(stalled), 64'd1);
        check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
        if (l != 0) begin
            check({tag, "/checksum"}, checksum, exp_ck);
        end else begin
            check({tag, "/len0_req"}, 64'(saw_req), 64'd0);
            check({tag, "/len0_busy"}, 64'(saw_busy), 64'd0);
        end
        check({tag, "/writes_left"}, 64'(exp_w.size()), 64'd0);
        check({tag, "/read_count"}, 64'(rlog.size()), 64'(exp_r.size()));
        for (int i = 0; i < exp_r.size() && i < rlog.size(); i++)
            check({tag, "/read_addr"}, 64'(rlog[i]), 64'(exp_r[i]));
        @(posedge clk);
        @(negedge clk);
        check({tag, "/done_pulse"}, 64'(done), 64'd0);
        check({tag, "/idle_busy"}, 64'(busy), 64'd0);
        check({tag, "/idle_req"}, 64'(m_req), 64'd0);
        if (l != 0) check({tag, "/checksum_hold"}, checksum, exp_ck);
    endtask

    // Abort a 4-word copy with reset during the second word's RDW
    task automatic reset_abort();
        logic [AW-1:0] s, d;
        int            cyc;
        s = 16'h0008; d = 16'h7018; cyc = 0;
        exp_w.delete();
        exp_w.push_back({d, ref_mem[s]});
        ref_mem[d] = ref_mem[s];
        @(negedge clk);
        src_addr = s; dst_addr = d; len = 8'd4; start = 1'b1; m_grant = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (!(exp_w.size() == 0 && m_req && !m_wr) && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("abort/reached_rd2", 64'(cyc < 100), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("abort/rdw_bus", {47'd0, m_req, m_wr, m_addr}, {47'd0, 1'b1, 1'b0, s + 16'd1});
        reset = 1'b1;
        #1;
        check("abort/m_req", 64'(m_req), 64'd0);
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/done", 64'(done), 64'd0);
        check("abort/m_addr", 64'(m_addr), 64'd0);
        check("abort/m_dout", m_dout, 64'd0);
        check("abort/checksum", checksum, 64'd0);
        repeat (2) @(negedge clk);
        check("abort/no_done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort/second_word_unwritten", mem[d + 16'd1], ref_mem[d + 16'd1]);
        check("abort/idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [AW-1:0] s, d;
        logic [LW-1:0] l;
        int            mode;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        #12;
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/done", 64'(done), 64'd0);
        check("rst/checksum", checksum, 64'd0);
        check("rst/m_req", 64'(m_req), 64'd0);
        check("rst/m_wr", 64'(m_wr), 64'd0);
        check("rst/m_addr", 64'(m_addr), 64'd0);
        check("rst/m_dout", m_dout, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_copy(16'h0005, 16'h7001, 8'd1, 0, 5, 1'b0, "single");
        check("single/model_cs", model_cs, 64'd1234);
        check("single/mem", mem[16'h7001], 64'd1234);

        run_copy(16'h0000, 16'h7010, 8'd4, 0, 14, 1'b0, "four");
        check("four/model_cs", model_cs, 64'd4);
        check("four/mem3", mem[16'h7013], 64'd4);

        run_copy(16'hFFFF, 16'h7100, 8'd2, 0, 8, 1'b0, "wrap");
        check("wrap/rd0", 64'(rlog[0]), 64'hFFFF);
        check("wrap/rd1", 64'(rlog[1]), 64'h0000);

        run_copy(16'h0010, 16'h7020, 8'd3, 2, 14, 1'b0, "stall");
        run_copy(16'h0000, 16'h7200, 8'd0, 0, 1, 1'b0, "len0");
        run_copy(16'h0014, 16'h7030, 8'd3, 0, 11, 1'b1, "poke");

        reset_abort();
        run_copy(16'h0008, 16'h7040, 8'd4, 0, 14, 1'b0, "after_rst");

        for (int k = 0; k < 10; k++) begin
            s = 16'($urandom);
            d = (k % 3 == 2) ? s + 16'($urandom_range(0, 3)) : 16'($urandom);
            l = 8'($urandom_range(1, 12));
            mode = k % 2;
            run_copy(s, d, l, mode, (mode == 0) ? 2 + 3 * int'(l) : -1, 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
